// File: rtl/jstk_dir_decoder.sv
// jstk_dir_decoder
//    Decodes the 40-bit PmodJSTK frame for player 2 into clean direction levels.
//    Threshold hysteresis plus a per-channel sample-count debounce produce UP/LEFT/RIGHT,
//    a debounced stick button, a one-clock jump pulse on UP rising, and a link-loss flag.
//
// Ports
//    clk         in   system clock
//    rst_n       in   asynchronous active-low reset
//    sample_en   in   one-cycle strobe, jstk_data holds a new valid frame
//    jstk_data   in   [39:0] PmodJSTK frame
//    pos_x       out  [9:0] latched X position
//    pos_y       out  [9:0] latched Y position
//    sig_u       out  debounced UP level
//    sig_l       out  debounced LEFT level
//    sig_r       out  debounced RIGHT level
//    jump_pulse  out  one clock high after each rise of sig_u
//    btn_stick   out  debounced stick button (jstk_data[0])
//    link_err    out  high while no frame has arrived for TIMEOUT_CYC cycles
module jstk_dir_decoder #(
   parameter int unsigned HI_ON       = 630,
   parameter int unsigned HI_OFF      = 600,
   parameter int unsigned LO_ON       = 300,
   parameter int unsigned LO_OFF      = 330,
   parameter int unsigned DEB_SAMPLES = 3,
   parameter int unsigned TIMEOUT_CYC = 2000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_en,
   input  logic [39:0] jstk_data,
   output logic [9:0]  pos_x,
   output logic [9:0]  pos_y,
   output logic        sig_u,
   output logic        sig_l,
   output logic        sig_r,
   output logic        jump_pulse,
   output logic        btn_stick,
   output logic        link_err
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [9:0]    HI_ON_V  = 10'(HI_ON);
   localparam logic [9:0]    HI_OFF_V = 10'(HI_OFF);
   localparam logic [9:0]    LO_ON_V  = 10'(LO_ON);
   localparam logic [9:0]    LO_OFF_V = 10'(LO_OFF);
   localparam logic [4:0]    DEB_V    = 5'(DEB_SAMPLES);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          u_q, u_d, l_q, l_d, r_q, r_d, b_q, b_d;
   logic [3:0]    cnt_u_q, cnt_u_d, cnt_l_q, cnt_l_d;
   logic [3:0]    cnt_r_q, cnt_r_d, cnt_b_q, cnt_b_d;
   logic          jump_q, jump_d, err_q, err_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic [9:0] new_x, new_y;
   logic       raw_u, raw_l, raw_r;

   // Returns {next_out, next_cnt} for one debounce channel on a sample.
   function automatic logic [4:0] deb_step(input logic raw, input logic out,
                                           input logic [3:0] cnt);
      logic [4:0] inc;
      inc = {1'b0, cnt} + 5'd1;
      if (raw == out) begin
         return {out, 4'd0};
      end else if (inc == DEB_V) begin
         return {~out, 4'd0};
      end else begin
         return {out, inc[3:0]};
      end
   endfunction

   assign new_x = {jstk_data[25:24], jstk_data[39:32]};
   assign new_y = {jstk_data[9:8], jstk_data[23:16]};

   always_comb begin
      raw_u = u_q ? (new_y >= HI_OFF_V) : (new_y >= HI_ON_V);
      // A side may only start counting once the opposite side has released, so LEFT and
      // RIGHT can never overlap even during a full-swing stick motion.
      raw_r = l_q ? 1'b0 : (r_q ? (new_x >= HI_OFF_V) : (new_x >= HI_ON_V));
      raw_l = r_q ? 1'b0 : (l_q ? (new_x <= LO_OFF_V) : (new_x <= LO_ON_V));
   end

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      u_d     = u_q;
      l_d     = l_q;
      r_d     = r_q;
      b_d     = b_q;
      cnt_u_d = cnt_u_q;
      cnt_l_d = cnt_l_q;
      cnt_r_d = cnt_r_q;
      cnt_b_d = cnt_b_q;
      err_d   = err_q;
      tmo_d   = tmo_q;

      if (sample_en) begin
         // A sample always wins over a timeout landing on the same edge.
         tmo_d = '0;
         err_d = 1'b0;
         x_d   = new_x;
         y_d   = new_y;
         {u_d, cnt_u_d} = deb_step(raw_u, u_q, cnt_u_q);
         {l_d, cnt_l_d} = deb_step(raw_l, l_q, cnt_l_q);
         {r_d, cnt_r_d} = deb_step(raw_r, r_q, cnt_r_q);
         {b_d, cnt_b_d} = deb_step(jstk_data[0], b_q, cnt_b_q);
         if (l_d && r_d) begin
            l_d     = l_q;
            r_d     = r_q;
            cnt_l_d = 4'd0;
            cnt_r_d = 4'd0;
         end
      end else if (tmo_q != TMO_MAX) begin
         tmo_d = tmo_q + 1'b1;
         if (tmo_d == TMO_MAX) begin
            err_d   = 1'b1;
            u_d     = 1'b0;
            l_d     = 1'b0;
            r_d     = 1'b0;
            b_d     = 1'b0;
            cnt_u_d = 4'd0;
            cnt_l_d = 4'd0;
            cnt_r_d = 4'd0;
            cnt_b_d = 4'd0;
         end
      end

      jump_d = u_d & ~u_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         u_q     <= 1'b0;
         l_q     <= 1'b0;
         r_q     <= 1'b0;
         b_q     <= 1'b0;
         cnt_u_q <= '0;
         cnt_l_q <= '0;
         cnt_r_q <= '0;
         cnt_b_q <= '0;
         jump_q  <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         u_q     <= u_d;
         l_q     <= l_d;
         r_q     <= r_d;
         b_q     <= b_d;
         cnt_u_q <= cnt_u_d;
         cnt_l_q <= cnt_l_d;
         cnt_r_q <= cnt_r_d;
         cnt_b_q <= cnt_b_d;
         jump_q  <= jump_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   assign pos_x      = x_q;
   assign pos_y      = y_q;
   assign sig_u      = u_q;
   assign sig_l      = l_q;
   assign sig_r      = r_q;
   assign btn_stick  = b_q;
   assign jump_pulse = jump_q;
   assign link_err   = err_q;

endmodule

// File: tb/tb_jstk_dir_decoder.sv
// tb_jstk_dir_decoder
//    Self-checking bench for jstk_dir_decoder with a short link timeout.
//    Expected outputs are queued as each step is driven and compared after the clock edge.
module tb_jstk_dir_decoder;

   logic        clk;
   logic        rst_n;
   logic        sample_en;
   logic [39:0] jstk_data;
   logic [9:0]  pos_x, pos_y;
   logic        sig_u, sig_l, sig_r, jump_pulse, btn_stick, link_err;

   jstk_dir_decoder #(
      .HI_ON      (630),
      .HI_OFF     (600),
      .LO_ON      (300),
      .LO_OFF     (330),
      .DEB_SAMPLES(3),
      .TIMEOUT_CYC(100)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .jstk_data (jstk_data),
      .pos_x     (pos_x),
      .pos_y     (pos_y),
      .sig_u     (sig_u),
      .sig_l     (sig_l),
      .sig_r     (sig_r),
      .jump_pulse(jump_pulse),
      .btn_stick (btn_stick),
      .link_err  (link_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       u, l, r, b, j, e;
      logic [9:0] x, y;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   task automatic compare_out(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check_eq({tag, ".sig_u"},      32'(sig_u),      32'(e.u));
      check_eq({tag, ".sig_l"},      32'(sig_l),      32'(e.l));
      check_eq({tag, ".sig_r"},      32'(sig_r),      32'(e.r));
      check_eq({tag, ".btn_stick"},  32'(btn_stick),  32'(e.b));
      check_eq({tag, ".jump_pulse"}, 32'(jump_pulse), 32'(e.j));
      check_eq({tag, ".link_err"},   32'(link_err),   32'(e.e));
      check_eq({tag, ".pos_x"},      32'(pos_x),      32'(e.x));
      check_eq({tag, ".pos_y"},      32'(pos_y),      32'(e.y));
   endtask

   task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic btn,
                        input string tag);
      jstk_data        = '0;
      jstk_data[39:32] = x[7:0];
      jstk_data[25:24] = x[9:8];
      jstk_data[23:16] = y[7:0];
      jstk_data[9:8]   = y[9:8];
      jstk_data[0]     = btn;
      sample_en        = 1'b1;
      cur.x = x;
      cur.y = y;
      sb.push_back(cur);
      @(posedge clk);
      #1;
      sample_en = 1'b0;
      compare_out(tag);
   endtask

   task automatic idle(input string tag);
      sample_en = 1'b0;
      sb.push_back(cur);
      @(posedge clk);
      #1;
      compare_out(tag);
   endtask

   task automatic check_now(input string tag);
      sb.push_back(cur);
      compare_out(tag);
   endtask

   initial begin
      cur       = '0;
      rst_n     = 1'b0;
      sample_en = 1'b0;
      jstk_data = '0;
      #12;
      check_now("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // UP asserts on the 3rd frame with a single jump pulse
      frame(10'd512, 10'd700, 1'b0, "up1");
      frame(10'd512, 10'd700, 1'b0, "up2");
      cur.u = 1'b1; cur.j = 1'b1;
      frame(10'd512, 10'd700, 1'b0, "up3");
      cur.j = 1'b0;
      idle("up_jump_end");

      // Hysteresis: 610 holds, 590 releases without a pulse
      repeat (5) frame(10'd512, 10'd610, 1'b0, "hys_hold");
      repeat (2) frame(10'd512, 10'd590, 1'b0, "hys_rel");
      cur.u = 1'b0;
      frame(10'd512, 10'd590, 1'b0, "hys_off");
      idle("hys_nojump");

      // Glitch reject on RIGHT
      frame(10'd650, 10'd512, 1'b0, "gl1");
      frame(10'd650, 10'd512, 1'b0, "gl2");
      frame(10'd500, 10'd512, 1'b0, "gl3");
      frame(10'd650, 10'd512, 1'b0, "gl4");
      frame(10'd650, 10'd512, 1'b0, "gl5");
      cur.r = 1'b1;
      frame(10'd650, 10'd512, 1'b0, "gl_on");

      // Centre the stick to release RIGHT
      repeat (2) frame(10'd512, 10'd512, 1'b0, "ctr_hold");
      cur.r = 1'b0;
      frame(10'd512, 10'd512, 1'b0, "ctr_off");

      // LEFT then full swing to RIGHT, no overlap
      repeat (2) frame(10'd100, 10'd512, 1'b0, "left_cnt");
      cur.l = 1'b1;
      frame(10'd100, 10'd512, 1'b0, "left_on");
      repeat (2) frame(10'd900, 10'd512, 1'b0, "sw_l_hold");
      cur.l = 1'b0;
      frame(10'd900, 10'd512, 1'b0, "sw_l_off");
      repeat (2) frame(10'd900, 10'd512, 1'b0, "sw_r_cnt");
      cur.r = 1'b1;
      frame(10'd900, 10'd512, 1'b0, "sw_r_on");

      // Link loss after 100 idle cycles
      repeat (2) frame(10'd900, 10'd700, 1'b0, "ll_up_cnt");
      cur.u = 1'b1; cur.j = 1'b1;
      frame(10'd900, 10'd700, 1'b0, "ll_up_on");
      cur.j = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         if (i == 100) begin
            cur.e = 1'b1; cur.u = 1'b0; cur.r = 1'b0;
         end
         idle((i == 100) ? "tmo_hit" : "tmo_wait");
      end
      repeat (2) idle("tmo_hold");

      // Recovery: first frame clears link_err and counts as sample 1
      cur.e = 1'b0;
      frame(10'd512, 10'd700, 1'b1, "rec1");
      frame(10'd512, 10'd700, 1'b1, "rec2");
      cur.u = 1'b1; cur.j = 1'b1; cur.b = 1'b1;
      frame(10'd512, 10'd700, 1'b1, "rec3");
      cur.j = 1'b0;

      // Sample on the would-be timeout edge keeps the link up
      repeat (99) idle("race_wait");
      frame(10'd512, 10'd700, 1'b1, "tmo_race");

      // Asynchronous reset with LEFT counter at 2
      frame(10'd100, 10'd700, 1'b1, "ar1");
      frame(10'd100, 10'd700, 1'b1, "ar2");
      #2;
      rst_n = 1'b0;
      #1;
      cur = '0;
      check_now("async_rst");
      #1;
      rst_n = 1'b1;
      frame(10'd100, 10'd512, 1'b0, "ar_post1");
      frame(10'd100, 10'd512, 1'b0, "ar_post2");
      cur.l = 1'b1;
      frame(10'd100, 10'd512, 1'b0, "ar_post3");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
